// File: rtl/kronos_mem_arbiter_pkg.sv
// Shared types for the kronos memory arbiter: port ownership and FSM state.
// Imported by kronos_mem_arbiter.
package kronos_mem_arbiter_pkg;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between fetch and LSU: issue in IDLE, gnt in ACCESS.
// Round-robin on contention; `define KRONOS_ARB_DATA_PRIORITY_EN makes DATA always win instead.
module kronos_mem_arbiter
  import kronos_mem_arbiter_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic [31:0]       instr_addr,
  input  logic              instr_req,
  output logic [31:0]       instr_data,
  output logic              instr_gnt,
  input  logic [31:0]       data_addr,
  input  logic              data_rd_req,
  input  logic              data_wr_req,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_wr_mask,
  output logic [31:0]       data_rd_data,
  output logic              data_gnt,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [3:0]        mem_wr_mask,
  input  logic [31:0]       mem_rdata
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  arb_owner_e win;
  logic       instr_act, data_act;
`ifndef KRONOS_ARB_DATA_PRIORITY_EN
  arb_owner_e last_q, last_d;
`endif

  // No issue may reach the SRAM while reset is held.
  assign instr_act = instr_req & rstz;
  assign data_act  = (data_rd_req | data_wr_req) & rstz;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
`ifndef KRONOS_ARB_DATA_PRIORITY_EN
    last_d      = last_q;
`endif
    win         = INSTR;
    instr_gnt   = 1'b0;
    data_gnt    = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_mask = 4'b0000;
    mem_wdata   = 32'h0;
    mem_addr    = '0;

    if (instr_act && data_act) begin
`ifdef KRONOS_ARB_DATA_PRIORITY_EN
      win = DATA;
`else
      win = (last_q == DATA) ? INSTR : DATA;
`endif
    end else if (data_act) begin
      win = DATA;
    end

    if (state_q == ACCESS) begin
      instr_gnt = (owner_q == INSTR);
      data_gnt  = (owner_q == DATA);
      state_d   = IDLE;
    end else if (instr_act || data_act) begin
      mem_en  = 1'b1;
      owner_d = win;
`ifndef KRONOS_ARB_DATA_PRIORITY_EN
      last_d  = win;
`endif
      state_d = ACCESS;
      if (win == DATA) begin
        mem_addr = data_addr[2 +: MEM_AW];
        // A simultaneous read+write request is serviced as the write.
        if (data_wr_req) begin
          mem_wr_en   = 1'b1;
          mem_wdata   = data_wr_data;
          mem_wr_mask = data_wr_mask;
        end
      end else begin
        mem_addr = instr_addr[2 +: MEM_AW];
      end
    end
  end

  assign instr_data   = mem_rdata;
  assign data_rd_data = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[31:2+MEM_AW], instr_addr[1:0],
                              data_addr[31:2+MEM_AW], data_addr[1:0]};

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      owner_q <= INSTR;
`ifndef KRONOS_ARB_DATA_PRIORITY_EN
      last_q  <= DATA;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifndef KRONOS_ARB_DATA_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Bench for kronos_mem_arbiter: bench-side SRAM, transaction-level reference model checked every cycle,
// plus directed literal checks for fetch, masked store, contention order and reset mid-access.
module tb_kronos_mem_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstz = 1'b0;
  logic [31:0]   instr_addr = '0;
  logic          instr_req = 1'b0;
  logic [31:0]   instr_data;
  logic          instr_gnt;
  logic [31:0]   data_addr = '0;
  logic          data_rd_req = 1'b0;
  logic          data_wr_req = 1'b0;
  logic [31:0]   data_wr_data = '0;
  logic [3:0]    data_wr_mask = '0;
  logic [31:0]   data_rd_data;
  logic          data_gnt;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_en;
  logic          mem_wr_en;
  logic [3:0]    mem_wr_mask;
  logic [31:0]   mem_rdata = '0;

  kronos_mem_arbiter #(.MEM_AW(AW)) dut (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_gnt(instr_gnt),
    .data_addr(data_addr), .data_rd_req(data_rd_req), .data_wr_req(data_wr_req),
    .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
    .data_rd_data(data_rd_data), .data_gnt(data_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_wr_mask(mem_wr_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Bench-side SRAM (the memory macro), unaffected by reset.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wr_mask);
      else           mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model: at most one transaction in flight; completes the cycle after issue.
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  bit            m_v = 0, m_port = 0, m_wr = 0, m_last = 1;
  logic [31:0]   m_rd;
  bit            ir, dr, mw;
  logic [31:0]   ma;
  logic [AW-1:0] mwd;

  always @(negedge clk) begin
    chk("gnt_exclusive", {31'b0, instr_gnt & data_gnt}, 32'd0);
    if (!rstz) begin
      chk("rst_instr_gnt", {31'b0, instr_gnt}, 32'd0);
      chk("rst_data_gnt", {31'b0, data_gnt}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
      chk("rst_mem_wr_mask", {28'b0, mem_wr_mask}, 32'd0);
      m_v = 0;
      m_last = 1;
    end else if (m_v) begin
      chk("resp_instr_gnt", {31'b0, instr_gnt}, {31'b0, !m_port});
      chk("resp_data_gnt", {31'b0, data_gnt}, {31'b0, m_port});
      chk("resp_mem_en", {31'b0, mem_en}, 32'd0);
      if (!m_wr) begin
        if (m_port) chk("resp_data_rd_data", data_rd_data, m_rd);
        else        chk("resp_instr_data", instr_data, m_rd);
      end
      m_v = 0;
    end else begin
      ir = instr_req;
      dr = data_rd_req | data_wr_req;
      chk("idle_gnts", {30'b0, instr_gnt, data_gnt}, 32'd0);
      if (!ir && !dr) begin
        chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
        chk("idle_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
        chk("idle_mem_wr_mask", {28'b0, mem_wr_mask}, 32'd0);
        chk("idle_mem_addr", {22'b0, mem_addr}, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end else begin
        if (ir && dr) begin
`ifdef KRONOS_ARB_DATA_PRIORITY_EN
          mw = 1;
`else
          mw = !m_last;
`endif
        end else begin
          mw = dr;
        end
        ma  = mw ? data_addr : instr_addr;
        mwd = ma[2 +: AW];
        chk("issue_mem_en", {31'b0, mem_en}, 32'd1);
        chk("issue_mem_addr", {22'b0, mem_addr}, {22'b0, mwd});
        chk("issue_mem_wr_en", {31'b0, mem_wr_en}, {31'b0, mw & data_wr_req});
        m_rd = ref_mem[mwd];
        m_wr = mw & data_wr_req;
        if (m_wr) begin
          chk("issue_mem_wdata", mem_wdata, data_wr_data);
          chk("issue_mem_wr_mask", {28'b0, mem_wr_mask}, {28'b0, data_wr_mask});
          ref_mem[mwd] = merge(ref_mem[mwd], data_wr_data, data_wr_mask);
        end
        m_port = mw;
        m_last = mw;
        m_v = 1;
      end
    end
  end

  // Grant log for ordering checks, cycles relative to the request-raise cycle c0.
  bit log_en = 0;
  int c0 = 0;
  int lp[$];
  int lc[$];
  always @(negedge clk) begin
    if (log_en) begin
      if (instr_gnt) begin lp.push_back(0); lc.push_back(cyc - c0); end
      if (data_gnt)  begin lp.push_back(1); lc.push_back(cyc - c0); end
    end
  end

  task automatic instr_op(input logic [31:0] a);
    bit got;
    @(posedge clk); #1;
    instr_addr = a;
    instr_req  = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (instr_gnt) got = 1;
    end
    chk("instr_gnt_wait", {31'b0, got}, 32'd1);
  endtask

  task automatic instr_idle();
    @(posedge clk); #1;
    instr_req = 1'b0;
  endtask

  task automatic data_op(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
    bit got;
    @(posedge clk); #1;
    data_addr    = a;
    data_rd_req  = rd;
    data_wr_req  = wr;
    data_wr_data = wd;
    data_wr_mask = m;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (data_gnt) got = 1;
    end
    chk("data_gnt_wait", {31'b0, got}, 32'd1);
  endtask

  task automatic data_idle();
    @(posedge clk); #1;
    data_rd_req = 1'b0;
    data_wr_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstz = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstz = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  int exp_p[$];
  int exp_c[$];
  logic [3:0] rm;
  int kind;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = 32'h5A5A0000 ^ (i * 32'h00010203);
      ref_mem[i] = 32'h5A5A0000 ^ (i * 32'h00010203);
    end
    sram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    sram[8]  = 32'h11223344; ref_mem[8]  = 32'h11223344;

    repeat (3) @(posedge clk);
    #1 rstz = 1'b1;

    // Single fetch
    @(posedge clk); #1;
    instr_addr = 32'h40;
    instr_req  = 1'b1;
    #1;
    chk("fetch_mem_en", {31'b0, mem_en}, 32'd1);
    chk("fetch_mem_addr", {22'b0, mem_addr}, 32'h10);
    @(negedge clk);
    @(negedge clk);
    chk("fetch_instr_gnt", {31'b0, instr_gnt}, 32'd1);
    chk("fetch_instr_data", instr_data, 32'hDEADBEEF);
    chk("fetch_data_gnt", {31'b0, data_gnt}, 32'd0);
    instr_idle();

    // Masked store, then read back
    @(posedge clk); #1;
    data_addr    = 32'h22;
    data_wr_req  = 1'b1;
    data_wr_data = 32'hAABBCCDD;
    data_wr_mask = 4'b1100;
    #1;
    chk("store_mem_wr_en", {31'b0, mem_wr_en}, 32'd1);
    chk("store_mem_addr", {22'b0, mem_addr}, 32'h8);
    @(negedge clk);
    @(negedge clk);
    chk("store_data_gnt", {31'b0, data_gnt}, 32'd1);
    data_idle();
    chk("store_sram8", sram[8], 32'hAABB3344);
    chk("store_model8", ref_mem[8], 32'hAABB3344);
    data_op(1, 0, 32'h23, 32'h0, 4'h0);
    chk("load_back", data_rd_data, 32'hAABB3344);
    data_idle();

    // Contention from reset
    do_reset();
    lp.delete(); lc.delete();
    @(negedge clk);
    c0 = cyc + 1;
    log_en = 1;
`ifdef KRONOS_ARB_DATA_PRIORITY_EN
    fork
      begin instr_op(32'h40); instr_idle(); end
      begin
        data_op(1, 0, 32'h20, 0, 0);
        data_op(1, 0, 32'h24, 0, 0);
        data_op(1, 0, 32'h28, 0, 0);
        data_idle();
      end
    join
    exp_p = '{1, 1, 1, 0};
    exp_c = '{1, 3, 5, 7};
`else
    fork
      begin
        instr_op(32'h40); instr_op(32'h44); instr_op(32'h48); instr_idle();
      end
      begin
        data_op(1, 0, 32'h20, 0, 0);
        data_op(0, 1, 32'h24, 32'hCAFEF00D, 4'hF);
        data_op(1, 0, 32'h24, 0, 0);
        data_idle();
      end
    join
    exp_p = '{0, 1, 0, 1, 0, 1};
    exp_c = '{1, 3, 5, 7, 9, 11};
`endif
    log_en = 0;
    chk("contention_count", lp.size(), exp_p.size());
    for (int i = 0; i < exp_p.size() && i < lp.size(); i++) begin
      chk($sformatf("contention_port_%0d", i), lp[i], exp_p[i]);
      chk($sformatf("contention_cycle_%0d", i), lc[i], exp_c[i]);
    end

    // Reset asserted during the ACCESS cycle
    @(posedge clk); #1;
    instr_addr = 32'h40;
    instr_req  = 1'b1;
    @(posedge clk); #1;
    rstz = 1'b0;
    @(negedge clk);
    chk("rst_mid_instr_gnt", {31'b0, instr_gnt}, 32'd0);
    instr_req = 1'b0;
    @(posedge clk); #1;
    rstz = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("post_rst_gnts", {30'b0, instr_gnt, data_gnt}, 32'd0);
    instr_op(32'h41);
    chk("post_rst_fetch", instr_data, 32'hDEADBEEF);
    instr_idle();

    // Randomized mixed traffic
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          instr_op({24'b0, $urandom_range(0, 63), 2'($urandom_range(0, 3))});
          if ($urandom_range(0, 3) == 0) instr_idle();
        end
        instr_idle();
      end
      begin
        for (int i = 0; i < 512; i++) begin
          kind = $urandom_range(0, 6);
          case (kind)
            3:       rm = 4'b0001 << $urandom_range(0, 3);
            4:       rm = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100;
            default: rm = 4'b1111;
          endcase
          data_op(kind <= 2 || kind == 6, kind >= 3,
                  {24'b0, $urandom_range(0, 63), 2'($urandom_range(0, 3))}, $urandom, rm);
          if ($urandom_range(0, 3) == 0) data_idle();
        end
        data_idle();
      end
    join
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
